mem_editor_ctrl: RTL and testbench
==================================

# mem_editor_ctrl

Control stage between the push-button edge detectors and the 1024×8 single-port synchronous RAM. Turns one-cycle button pulses plus switch data into RAM write and read cycles. Holds the current address and the byte stored there, and presents both as nibbles to the seven-segment decoders. Handles the RAM's one-cycle registered read latency and its write-through read port (q takes the written data on a write).

## Interface
- ADDR_W, 10, RAM address width; address arithmetic wraps modulo 2^ADDR_W
- DATA_W, 8, RAM data width and switch width
- clk  in  1  single system clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- sw  in  DATA_W  switch value; used as write data or as load address (low ADDR_W bits, zero-extended if DATA_W < ADDR_W)
- auto_inc  in  1  level; when 1, a write advances the address afterwards
- p_load  in  1  one-cycle pulse: load address from sw
- p_write  in  1  one-cycle pulse: write sw to current address
- p_next  in  1  one-cycle pulse: address + 1
- p_prev  in  1  one-cycle pulse: address − 1
- ram_q  in  DATA_W  RAM registered read data
- ram_we  out  1  RAM write enable (registered)
- ram_addr  out  ADDR_W  RAM address (registered; also the displayed address)
- ram_data  out  DATA_W  RAM write data (registered)
- disp_data  out  DATA_W  byte last captured from ram_q
- busy  out  1  high whenever state ≠ IDLE (combinational from state)

## Operation
- States: IDLE, WR, RD, CAP.
- Reset values:
  - ram_we=0, ram_addr=0, ram_data=0, disp_data=0.
  - State=RD, so busy=1.
  - Reset therefore triggers a read of address 0.
- IDLE: one pulse accepted per edge. Priority is p_load > p_write > p_next > p_prev; the lower-priority simultaneous pulses are discarded.
  - p_load: ram_addr←sw[ADDR_W-1:0], state←RD.
  - p_write: ram_we←1, ram_data←sw, state←WR.
  - p_next: ram_addr←ram_addr+1 (1023→0), state←RD.
  - p_prev: ram_addr←ram_addr−1 (0→1023), state←RD.
  - No pulse: hold.
- WR: the RAM commits at this edge (old address); ram_we←0.
  - auto_inc=0: state←CAP. ram_q then holds the written byte.
  - auto_inc=1: ram_addr←ram_addr+1 (wraps), state←RD.
  - auto_inc is sampled in WR, not at pulse time.
- RD: ram_we=0 and address stable; the RAM samples it at this edge. state←CAP.
- CAP: disp_data←ram_q, state←IDLE.
- Pulses arriving while busy=1 are dropped, not queued.
- rst in any state overrides everything.
  - An in-flight write whose WR edge coincides with rst is not committed, because ram_we is forced to 0 during rst.
- ram_we is high for exactly one cycle per accepted p_write.

## Timing
- Edge E0 is the IDLE edge that samples a pulse.
- Navigation/load: ram_addr changes at E0; disp_data changes at E0+2; busy is high for 2 cycles.
- Write, auto_inc=0: ram_we is high during the E0→E0+1 cycle; the memory is written at E0+1; disp_data=sw value at E0+2; busy for 2 cycles.
- Write, auto_inc=1: memory written at E0+1; ram_addr=old+1 after E0+1; disp_data=mem[old+1] after E0+3; busy for 3 cycles.
- After reset deasserts at edge R: disp_data=mem[0] after R+1; IDLE from R+1.
  - For the first edge after reset, the RAM is still sampling address 0.

## Structure
- Shared package holds:
  - the state enum (IDLE, WR, RD, CAP), 2 bits;
  - ADDR_W/DATA_W defaults;
  - the constant MEM_DEPTH = 2^ADDR_W.
- One natural sub-module: addr_step.
  - Combinational; inputs ram_addr, inc, dec; output wrapped next address.
  - Shared by the navigation and auto-increment paths.
- The RAM, edge detectors and hex decoders are instantiated by the parent top level, not inside this block.

## Test plan
- Reset, then release with RAM preloaded mem[0]=8'h5A → disp_data=8'h5A after 1 edge; ram_addr=0; busy=0 by the second edge.
- p_write with sw=8'h3C, auto_inc=0, at addr 5 → one cycle of ram_we=1, addr=5, data=3C; disp_data=3C two edges later; mem[5]=3C.
- auto_inc=1, three writes 11, 22, 33 starting at addr 1022 → mem[1022]=11, mem[1023]=22, mem[0]=33; final ram_addr=1; busy for 3 cycles per write.
- At addr 0:
  - p_prev → ram_addr=1023, disp_data=mem[1023].
  - Then p_next → ram_addr=0.
- p_load and p_write in the same cycle with sw=8'h80 → ram_addr=128 and no write.
  - Then p_next while busy → ignored; ram_addr stays 128.
- rst asserted in the WR cycle of a write to addr 7 → mem[7] unchanged; ram_addr=0; ram_we=0.

Source files
------------

// File: rtl/mem_editor_ctrl_pkg.sv
// mem_editor_ctrl_pkg: shared widths, memory depth and controller state encoding
package mem_editor_ctrl_pkg;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 8;
  localparam int MEM_DEPTH = 1 << DEF_ADDR_W;
  typedef enum logic [1:0] {IDLE, WR, RD, CAP} state_t;
endpackage

// File: rtl/mem_editor_ctrl_addr_step.sv
// mem_editor_ctrl_addr_step: wrapping +1/-1 address stepper shared by navigation and auto-increment
module mem_editor_ctrl_addr_step
  import mem_editor_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic              inc,
  input  logic              dec,
  output logic [ADDR_W-1:0] next_addr
);
  assign next_addr = ram_addr + ADDR_W'(inc) - ADDR_W'(dec);
endmodule

// File: rtl/mem_editor_ctrl.sv
// mem_editor_ctrl: turns button pulses and switches into RAM write/read cycles and latches the displayed byte
module mem_editor_ctrl
  import mem_editor_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sw,
  input  logic              auto_inc,
  input  logic              p_load,
  input  logic              p_write,
  input  logic              p_next,
  input  logic              p_prev,
  input  logic [DATA_W-1:0] ram_q,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic [DATA_W-1:0] disp_data,
  output logic              busy
);
  state_t r_state, w_state;
  logic r_we, w_we;
  logic [ADDR_W-1:0] r_addr, w_addr, w_step, w_ld_addr;
  logic [DATA_W-1:0] r_data, w_data, r_disp, w_disp;
  logic w_inc, w_dec, w_nav;
  assign w_ld_addr = ADDR_W'(sw);
  assign w_nav = (r_state == IDLE) && !p_load && !p_write;
  assign w_inc = (r_state == WR) ? auto_inc : (w_nav && p_next);
  assign w_dec = w_nav && !p_next && p_prev;
  mem_editor_ctrl_addr_step #(.ADDR_W(ADDR_W)) u_step (
    .ram_addr (r_addr),
    .inc      (w_inc),
    .dec      (w_dec),
    .next_addr(w_step)
  );
  always_comb begin
    w_state = r_state;
    w_we = 1'b0;
    w_addr = r_addr;
    w_data = r_data;
    w_disp = r_disp;
    case (r_state)
      IDLE: begin
        if (p_load) begin
          w_addr = w_ld_addr;
          w_state = RD;
        end else if (p_write) begin
          w_we = 1'b1;
          w_data = sw;
          w_state = WR;
        end else if (p_next || p_prev) begin
          w_addr = w_step;
          w_state = RD;
        end
      end
      WR: begin
        w_addr = w_step;
        w_state = auto_inc ? RD : CAP;
      end
      RD: w_state = CAP;
      default: begin
        w_disp = ram_q;
        w_state = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RD;
      r_we <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_disp <= '0;
    end else begin
      r_state <= w_state;
      r_we <= w_we;
      r_addr <= w_addr;
      r_data <= w_data;
      r_disp <= w_disp;
    end
  end
  // gating with rst keeps a write whose commit edge meets reset out of the RAM
  assign ram_we = r_we && !rst;
  assign ram_addr = r_addr;
  assign ram_data = r_data;
  assign disp_data = r_disp;
  assign busy = (r_state != IDLE);
endmodule

// File: tb/tb_mem_editor_ctrl.sv
// tb_mem_editor_ctrl: directed table, corner sequences and random ops against a transaction-level model
module tb_mem_editor_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] sw;
  logic auto_inc, p_load, p_write, p_next, p_prev;
  logic [7:0] ram_q;
  logic ram_we;
  logic [9:0] ram_addr;
  logic [7:0] ram_data, disp_data;
  logic busy;
  logic pre;
  logic [7:0] mem [1024];
  logic [7:0] ref_mem [1024];
  logic [9:0] ref_addr;
  logic [7:0] ref_disp;
  int ref_cyc, ref_we, act_cyc, act_we;
  int tests = 0, fails = 0;

  typedef struct {
    logic [3:0] p;
    logic [7:0] s;
    logic       a;
    logic [9:0] ea;
    logic [7:0] ed;
    int         ec;
    int         ew;
  } vec_t;
  vec_t tbl[11];

  always #5 clk = ~clk;

  mem_editor_ctrl dut (
    .clk(clk), .rst(rst), .sw(sw), .auto_inc(auto_inc),
    .p_load(p_load), .p_write(p_write), .p_next(p_next), .p_prev(p_prev),
    .ram_q(ram_q), .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
    .disp_data(disp_data), .busy(busy)
  );

  function automatic logic [7:0] init_val(int i);
    logic [7:0] v;
    v = 8'(i) ^ 8'hFF;
    return (i == 0) ? 8'h5A : v;
  endfunction

  always @(posedge clk) begin
    if (pre) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
    end else begin
      if (ram_we) mem[ram_addr] <= ram_data;
      ram_q <= ram_we ? ram_data : mem[ram_addr];
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model(input logic [3:0] p, input logic [7:0] s, input logic a);
    ref_cyc = 0;
    ref_we = 0;
    if (p[3]) ref_addr = 10'(s);
    else if (p[2]) begin
      ref_mem[ref_addr] = s;
      ref_we = 1;
      if (a) ref_addr = ref_addr + 10'd1;
    end else if (p[1]) ref_addr = ref_addr + 10'd1;
    else if (p[0]) ref_addr = ref_addr - 10'd1;
    if (p != 4'b0) begin
      ref_disp = ref_mem[ref_addr];
      ref_cyc = (!p[3] && p[2] && a) ? 3 : 2;
    end
  endtask

  task automatic do_op(input logic [3:0] p, input logic [7:0] s, input logic a, input logic [3:0] inj);
    @(negedge clk);
    {p_load, p_write, p_next, p_prev} = p;
    sw = s;
    auto_inc = a;
    model(p, s, a);
    @(posedge clk);
    #1;
    {p_load, p_write, p_next, p_prev} = inj;
    act_cyc = 0;
    act_we = 0;
    while (busy && act_cyc < 20) begin
      act_cyc++;
      act_we += int'(ram_we);
      @(posedge clk);
      #1;
      {p_load, p_write, p_next, p_prev} = 4'b0;
    end
    {p_load, p_write, p_next, p_prev} = 4'b0;
  endtask

  initial begin
    int bad;
    logic [3:0] rp;
    tbl[0]  = '{4'b1000, 8'h05, 1'b0, 10'h005, 8'hFA, 2, 0};
    tbl[1]  = '{4'b0100, 8'h3C, 1'b0, 10'h005, 8'h3C, 2, 1};
    tbl[2]  = '{4'b1000, 8'h00, 1'b0, 10'h000, 8'h5A, 2, 0};
    tbl[3]  = '{4'b0001, 8'h00, 1'b0, 10'h3FF, 8'h00, 2, 0};
    tbl[4]  = '{4'b0010, 8'h00, 1'b0, 10'h000, 8'h5A, 2, 0};
    tbl[5]  = '{4'b0001, 8'h00, 1'b0, 10'h3FF, 8'h00, 2, 0};
    tbl[6]  = '{4'b0001, 8'h00, 1'b0, 10'h3FE, 8'h01, 2, 0};
    tbl[7]  = '{4'b0100, 8'h11, 1'b1, 10'h3FF, 8'h00, 3, 1};
    tbl[8]  = '{4'b0100, 8'h22, 1'b1, 10'h000, 8'h5A, 3, 1};
    tbl[9]  = '{4'b0100, 8'h33, 1'b1, 10'h001, 8'hFE, 3, 1};
    tbl[10] = '{4'b1100, 8'h80, 1'b0, 10'h080, 8'h7F, 2, 0};
    rst = 1'b1; pre = 1'b1; sw = 8'h0; auto_inc = 1'b0;
    {p_load, p_write, p_next, p_prev} = 4'b0;
    repeat (2) @(posedge clk);
    #1 pre = 1'b0;
    @(posedge clk); #1;
    chk("rst_we", int'(ram_we), 0);
    chk("rst_addr", int'(ram_addr), 0);
    chk("rst_disp", int'(disp_data), 0);
    chk("rst_busy", int'(busy), 1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_busy_r", int'(busy), 1);
    @(posedge clk); #1;
    chk("rel_disp", int'(disp_data), 8'h5A);
    chk("rel_busy", int'(busy), 0);
    chk("rel_addr", int'(ram_addr), 0);
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    ref_addr = 10'd0;
    ref_disp = 8'h5A;

    for (int i = 0; i < 11; i++) begin
      do_op(tbl[i].p, tbl[i].s, tbl[i].a, 4'b0);
      chk($sformatf("tbl%0d_addr", i), int'(ram_addr), int'(tbl[i].ea));
      chk($sformatf("tbl%0d_disp", i), int'(disp_data), int'(tbl[i].ed));
      chk($sformatf("tbl%0d_busy", i), act_cyc, tbl[i].ec);
      chk($sformatf("tbl%0d_we", i), act_we, tbl[i].ew);
    end
    chk("mem_3fe", int'(mem[1022]), 8'h11);
    chk("mem_3ff", int'(mem[1023]), 8'h22);
    chk("mem_000", int'(mem[0]), 8'h33);
    chk("mem_005", int'(mem[5]), 8'h3C);
    chk("mem_080", int'(mem[128]), 8'h7F);

    do_op(4'b1000, 8'h80, 1'b0, 4'b0010);
    chk("drop_addr", int'(ram_addr), 10'h080);
    chk("drop_disp", int'(disp_data), 8'h7F);
    chk("drop_busy", act_cyc, 2);

    do_op(4'b1000, 8'h07, 1'b0, 4'b0);
    chk("ld7_disp", int'(disp_data), 8'hF8);
    @(negedge clk);
    p_write = 1'b1; sw = 8'h99; auto_inc = 1'b0;
    @(posedge clk); #1;
    p_write = 1'b0;
    chk("wr_we", int'(ram_we), 1);
    rst = 1'b1;
    #1 chk("rstwr_we_now", int'(ram_we), 0);
    @(posedge clk); #1;
    chk("rstwr_mem7", int'(mem[7]), 8'hF8);
    chk("rstwr_addr", int'(ram_addr), 0);
    chk("rstwr_we", int'(ram_we), 0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ref_addr = 10'd0;
    ref_disp = ref_mem[0];
    chk("rstwr_disp", int'(disp_data), int'(ref_disp));
    chk("rstwr_idle", int'(busy), 0);

    for (int i = 0; i < 300; i++) begin
      rp = 4'($urandom_range(0, 15));
      do_op(rp, 8'($urandom), 1'($urandom), 4'($urandom));
      chk($sformatf("rnd%0d_addr", i), int'(ram_addr), int'(ref_addr));
      chk($sformatf("rnd%0d_disp", i), int'(disp_data), int'(ref_disp));
      chk($sformatf("rnd%0d_busy", i), act_cyc, ref_cyc);
      chk($sformatf("rnd%0d_we", i), act_we, ref_we);
    end
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_final_bad_words", bad, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
